// File: rtl/vga_select_scheduler.sv
// vga_select_scheduler
//   Frame-synchronous controller for the colour select of the VGA pixel stage.
//   Colour-change requests arrive over a level req / pulse ack handshake. They
//   are applied only on a frame boundary (vsync falling edge), so the displayed
//   colour never changes mid-frame. An optional auto-cycle mode increments the
//   colour every FRAMES_PER_STEP frames.
//
// Parameters
//   FRAMES_PER_STEP : auto-cycle period in frames (>= 1)
//   INIT_SEL        : select value after reset
// Ports
//   clk        in   pixel clock (same clock as the sync generator)
//   rst        in   asynchronous active-low reset
//   vsync      in   active-low vertical sync, already in the clk domain
//   req        in   colour-change request, level, held until ack
//   req_sel    in   requested colour {R,G,B}, stable while req is high
//   auto_en    in   auto-cycle enable, sampled only on frame boundaries
//   select     out  registered colour select to the pixel stage
//   ack        out  one-cycle pulse when the request has been applied
//   busy       out  a request is accepted and pending (state != IDLE)
//   frame_tick out  one-cycle pulse per frame boundary
module vga_select_scheduler #(
  parameter int         FRAMES_PER_STEP = 60,
  parameter logic [2:0] INIT_SEL        = 3'b111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       req,
  input  logic [2:0] req_sel,
  input  logic       auto_en,
  output logic [2:0] select,
  output logic       ack,
  output logic       busy,
  output logic       frame_tick
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    APPLY = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             vsync_d;
  logic             boundary;
  logic             take_req;
  logic             do_apply;
  logic [2:0]       pend_sel;
  logic [CNT_W-1:0] cnt;

  // vsync falling edge: the one cycle per frame where changes are allowed
  assign boundary = vsync_d & ~vsync;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    take_req  = 1'b0;
    do_apply  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          take_req  = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND: begin
        if (boundary) begin
          do_apply  = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_d    <= 1'b1;
      frame_tick <= 1'b0;
      ack        <= 1'b0;
      pend_sel   <= 3'b000;
      select     <= INIT_SEL;
      cnt        <= '0;
    end else begin
      vsync_d    <= vsync;
      frame_tick <= boundary;
      ack        <= do_apply;
      if (take_req) begin
        pend_sel <= req_sel;
      end
      // A manual apply overrides any auto step due on the same boundary and
      // restarts the auto-cycle period from this frame.
      if (do_apply) begin
        select <= pend_sel;
        cnt    <= '0;
      end else if (boundary) begin
        if (auto_en) begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            select <= select + 3'd1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule
